pipe_stage_reg: RTL and testbench

//   Generic elastic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_pkg.sv | 23 ++
 rtl/pipe_stage_if.sv | 42 ++++
 rtl/pipe_stage_stats.sv | 42 ++++
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the elastic pipeline stage register:
// FSM state encoding, the default bubble control value, counter width,
// and a helper that derives input acceptance from the FSM state.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    // Control value of a bubble: no writes, no side effects.
    localparam int CTRL_NOP_DEFAULT = 0;

    // Width of the optional statistics counters.
    localparam int STATS_W = 32;

    // The stage takes a new entry in every state except when both slots are occupied.
    function automatic logic state_accepts(input state_e st);
        return (st != ST_SKID);
    endfunction

endpackage

// File: rtl/pipe_stage_if.sv
// Handshake bundle of one pipeline stage: upstream side (in_*) and
// downstream side (out_*). The stage register uses the slave view,
// the environment driving it uses the master view.
interface pipe_stage_if #(
    parameter int DATA_W = 32,
    parameter int N_DATA = 7,
    parameter int CTRL_W = 10
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [N_DATA*DATA_W-1:0] in_data;
    logic [CTRL_W-1:0]        in_ctrl;

    logic                     out_valid;
    logic                     out_ready;
    logic [N_DATA*DATA_W-1:0] out_data;
    logic [CTRL_W-1:0]        out_ctrl;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_ctrl,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_ctrl
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_ctrl,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_ctrl
    );

endinterface

// File: rtl/pipe_stage_stats.sv
// Optional statistics for a pipeline stage register:
//   stall_cnt counts cycles where the head entry is valid but not taken,
//   flush_cnt counts cycles with flush asserted outside reset.
// Both wrap modulo 2^32 and clear on reset.
module pipe_stage_stats
    import pipe_stage_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               out_valid,
    input  logic               out_ready,
    output logic [STATS_W-1:0] stall_cnt,
    output logic [STATS_W-1:0] flush_cnt
);

    logic [STATS_W-1:0] stall_cnt_r;
    logic [STATS_W-1:0] flush_cnt_r;

    // Count stalled-head cycles and flush cycles; reset clears both.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_r <= {STATS_W{1'b0}};
            flush_cnt_r <= {STATS_W{1'b0}};
        end else begin
            if (out_valid && !out_ready) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register with a 2-entry skid buffer.
// The main slot drives out_* directly; the skid slot catches the one
// entry that can arrive while the head is stalled. in_ready is a register
// derived from the next FSM state, so no combinational path runs from
// out_ready or flush back to the upstream stage.
// Build option: define PIPE_STAGE_STATS_EN to add stall_cnt / flush_cnt.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_DATA = 7,
    parameter int CTRL_W = 10,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEFAULT)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    pipe_stage_if.slave  bus
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STATS_W-1:0] stall_cnt,
    output logic [STATS_W-1:0] flush_cnt
`endif
);

    localparam int BUS_W = N_DATA * DATA_W;

    state_e             state_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [BUS_W-1:0]   out_data_r;
    logic [CTRL_W-1:0]  out_ctrl_r;
    logic [BUS_W-1:0]   skid_data_r;
    logic [CTRL_W-1:0]  skid_ctrl_r;

    logic               in_fire_s;
    logic               out_fire_s;

    assign in_fire_s  = bus.in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & bus.out_ready;

    // Stage FSM with main/skid storage; reset beats flush beats normal flow.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= {BUS_W{1'b0}};
            out_ctrl_r  <= CTRL_NOP;
            skid_data_r <= {BUS_W{1'b0}};
            skid_ctrl_r <= CTRL_NOP;
        end else if (flush) begin
            // Drop everything held; out_data keeps its stale value as a don't-care.
            state_r     <= ST_EMPTY;
            in_ready_r  <= state_accepts(ST_EMPTY);
            out_valid_r <= 1'b0;
            out_ctrl_r  <= CTRL_NOP;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_r     <= ST_FULL;
                        in_ready_r  <= state_accepts(ST_FULL);
                        out_valid_r <= 1'b1;
                        out_data_r  <= bus.in_data;
                        out_ctrl_r  <= bus.in_ctrl;
                    end else begin
                        state_r     <= ST_EMPTY;
                        in_ready_r  <= state_accepts(ST_EMPTY);
                    end
                end
                ST_FULL: begin
                    if (in_fire_s && out_fire_s) begin
                        // Head leaves while a new entry arrives: replace in place.
                        state_r     <= ST_FULL;
                        in_ready_r  <= state_accepts(ST_FULL);
                        out_data_r  <= bus.in_data;
                        out_ctrl_r  <= bus.in_ctrl;
                    end else if (in_fire_s) begin
                        // Head stalled: park the newcomer in the skid slot.
                        state_r     <= ST_SKID;
                        in_ready_r  <= state_accepts(ST_SKID);
                        skid_data_r <= bus.in_data;
                        skid_ctrl_r <= bus.in_ctrl;
                    end else if (out_fire_s) begin
                        state_r     <= ST_EMPTY;
                        in_ready_r  <= state_accepts(ST_EMPTY);
                        out_valid_r <= 1'b0;
                        out_ctrl_r  <= CTRL_NOP;
                    end else begin
                        state_r     <= ST_FULL;
                        in_ready_r  <= state_accepts(ST_FULL);
                    end
                end
                ST_SKID: begin
                    if (out_fire_s) begin
                        // Promote the skid entry to the head; order stays FIFO.
                        state_r     <= ST_FULL;
                        in_ready_r  <= state_accepts(ST_FULL);
                        out_data_r  <= skid_data_r;
                        out_ctrl_r  <= skid_ctrl_r;
                    end else begin
                        state_r     <= ST_SKID;
                        in_ready_r  <= state_accepts(ST_SKID);
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean bubble.
                    state_r     <= ST_EMPTY;
                    in_ready_r  <= state_accepts(ST_EMPTY);
                    out_valid_r <= 1'b0;
                    out_ctrl_r  <= CTRL_NOP;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_ctrl  = out_ctrl_r;

`ifdef PIPE_STAGE_STATS_EN
    pipe_stage_stats u_stats (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .out_valid (out_valid_r),
        .out_ready (bus.out_ready),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed scenarios followed by random traffic.
// The reference is a plain 2-deep FIFO queue of expected entries; a monitor
// on the falling edge compares the DUT against it every cycle.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int N_DATA = 7;
    localparam int CTRL_W = 10;
    localparam int BUS_W  = N_DATA * DATA_W;
    localparam logic [CTRL_W-1:0] NOP = 10'd0;

    typedef struct {
        logic [BUS_W-1:0]  data;
        logic [CTRL_W-1:0] ctrl;
    } item_t;

    logic clock;
    logic reset;
    logic flush;

    pipe_stage_if #(.DATA_W(DATA_W), .N_DATA(N_DATA), .CTRL_W(CTRL_W)) bus ();

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] stall_m;
    logic [31:0] flush_m;
`endif

    pipe_stage_reg #(.DATA_W(DATA_W), .N_DATA(N_DATA), .CTRL_W(CTRL_W)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    int    total = 0;
    int    bad   = 0;
    item_t exp_q[$];
    bit    checking  = 1'b0;
    bit    zero_data = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor/scoreboard: check the state left by the last edge, then advance the model.
    always @(negedge clock) begin
        if (checking) begin
            chk("out_valid", bus.out_valid, exp_q.size() != 0);
            chk("in_ready", bus.in_ready, exp_q.size() < 2);
            if (exp_q.size() != 0) begin
                chk("out_data", bus.out_data, exp_q[0].data);
                chk("out_ctrl", bus.out_ctrl, exp_q[0].ctrl);
            end else begin
                chk("bubble_ctrl", bus.out_ctrl, NOP);
            end
            if (zero_data) chk("reset_data", bus.out_data, '0);
`ifdef PIPE_STAGE_STATS_EN
            chk("stall_cnt", stall_cnt, stall_m);
            chk("flush_cnt", flush_cnt, flush_m);
`endif
        end
        if (reset) begin
            exp_q.delete();
            zero_data = 1'b1;
            checking  = 1'b1;
`ifdef PIPE_STAGE_STATS_EN
            stall_m = 32'd0;
            flush_m = 32'd0;
`endif
        end else begin
            automatic bit acc  = bus.in_valid && (exp_q.size() < 2);
            automatic bit fire = (exp_q.size() != 0) && bus.out_ready;
            automatic item_t it;
`ifdef PIPE_STAGE_STATS_EN
            if ((exp_q.size() != 0) && !bus.out_ready) stall_m = stall_m + 32'd1;
            if (flush) flush_m = flush_m + 32'd1;
`endif
            if (fire) void'(exp_q.pop_front());
            if (flush) begin
                exp_q.delete();
            end else if (acc) begin
                it.data = bus.in_data;
                it.ctrl = bus.in_ctrl;
                exp_q.push_back(it);
                zero_data = 1'b0;
            end
        end
    end

    // Drive one cycle of inputs; other data words are derived from word 0.
    task automatic step(input logic v, input logic [31:0] w0, input logic [CTRL_W-1:0] c,
                        input logic fl, input logic ordy);
        logic [BUS_W-1:0] d;
        for (int i = 0; i < N_DATA; i++) d[i*DATA_W +: DATA_W] = w0 ^ (32'h1111_1111 * i);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_ctrl   = c;
        bus.out_ready = ordy;
        flush         = fl;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step(1'b1, 32'hDEAD_BEEF, 10'h3FF, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = '0;
        bus.in_ctrl   = 10'h3FF;
        bus.out_ready = 1'b0;

        // 1: reset with a valid entry offered for three cycles
        do_reset(3);
        step(1'b0, 32'd0, 10'd0, 1'b0, 1'b1);

        // 2: streaming with the downstream always ready
        step(1'b1, 32'h100, 10'h011, 1'b0, 1'b1);
        step(1'b1, 32'h104, 10'h022, 1'b0, 1'b1);
        step(1'b1, 32'h108, 10'h033, 1'b0, 1'b1);
        step(1'b0, 32'd0,   10'd0,   1'b0, 1'b1);
        step(1'b0, 32'd0,   10'd0,   1'b0, 1'b1);

        // 3: fill main and skid while stalled, hold 0xC upstream, then drain
        step(1'b1, 32'hA, 10'h0A1, 1'b0, 1'b0);
        step(1'b1, 32'hB, 10'h0B2, 1'b0, 1'b0);
        step(1'b1, 32'hC, 10'h0C3, 1'b0, 1'b0);
        step(1'b1, 32'hC, 10'h0C3, 1'b0, 1'b0);
        step(1'b1, 32'hC, 10'h0C3, 1'b0, 1'b1);
        step(1'b1, 32'hC, 10'h0C3, 1'b0, 1'b1);
        step(1'b0, 32'd0, 10'd0,   1'b0, 1'b1);
        step(1'b0, 32'd0, 10'd0,   1'b0, 1'b1);

        // 4: flush while in SKID with a competing input
        step(1'b1, 32'hA, 10'h0A1, 1'b0, 1'b0);
        step(1'b1, 32'hB, 10'h0B2, 1'b0, 1'b0);
        step(1'b1, 32'hD, 10'h0D4, 1'b1, 1'b0);
        step(1'b0, 32'd0, 10'd0,   1'b0, 1'b1);

        // 5: input and flush together in EMPTY, then the same input alone
        step(1'b1, 32'hE, 10'h0E5, 1'b1, 1'b1);
        step(1'b1, 32'hE, 10'h0E5, 1'b0, 1'b1);
        step(1'b0, 32'd0, 10'd0,   1'b0, 1'b1);
        step(1'b0, 32'd0, 10'd0,   1'b0, 1'b1);

        // Random traffic with rare flushes and resets
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            step($urandom_range(0, 3) != 0, $urandom, CTRL_W'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 10'd0, 1'b0, 1'b1);
        @(negedge clock);
        chk("drain", exp_q.size(), 0);

`ifdef PIPE_STAGE_STATS_EN
        // 6: five stalled cycles, then two flush cycles, then reset
        do_reset(1);
        step(1'b1, 32'h60, 10'h066, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 10'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 32'd0, 10'd0, 1'b1, 1'b1);
        @(negedge clock);
        chk("stall_five", stall_cnt, 32'd5);
        chk("flush_two", flush_cnt, 32'd2);
        @(posedge clock);
        #1;
        do_reset(1);
        @(negedge clock);
        chk("stall_clr", stall_cnt, 32'd0);
        chk("flush_clr", flush_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
